// File: rtl/duck_motion_ctl.sv
// duck_motion_ctl: generates the duck's on-screen position and motion state.
//
// A free-running prescaler produces a one-cycle motion tick every TICK_DIV
// clocks. All position changes happen on tick cycles. State changes driven by
// hunt_start, duck_killed and game_enable take effect on the next edge,
// independent of the tick.
//
// Ports:
//   clk           pixel clock, posedge
//   rst_n         asynchronous active-low reset
//   game_enable   game running; low forces IDLE with the reset position
//   hunt_start    level, 1 while hunting; spawns the duck from IDLE
//   duck_killed   pulse on a successful hit; acted on in FLYING/ESCAPING only
//   duck_xpos     sprite left edge (registered)
//   duck_ypos     sprite top edge (registered)
//   duck_dir      facing, 1 = right, 0 = left
//   duck_state    0 IDLE, 1 FLYING, 2 ESCAPING, 3 HIT, 4 FALLING (FSM state)
//   duck_visible  1 in every state except IDLE
//   duck_escaped  one-cycle pulse when the duck leaves the top edge
//   duck_landed   one-cycle pulse when a falling duck reaches the ground
//
// Interface semantics: there is no valid/ready handshake. hunt_start is a
// level sampled every cycle; duck_killed is a single-cycle event sampled on
// every cycle, so it is never lost to the tick pacing.

module duck_motion_ctl #(
    parameter int SCREEN_W    = 1024,
    parameter int GROUND_Y    = 600,
    parameter int DUCK_W      = 96,
    parameter int DUCK_H      = 60,
    parameter int TICK_DIV    = 650_000,
    parameter int START_SPEED = 2,
    parameter int MAX_SPEED   = 8,
    parameter int FLY_TICKS   = 800,
    parameter int HIT_TICKS   = 50,
    parameter int FALL_STEP   = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        game_enable,
    input  logic        hunt_start,
    input  logic        duck_killed,
    output logic [11:0] duck_xpos,
    output logic [11:0] duck_ypos,
    output logic        duck_dir,
    output logic [2:0]  duck_state,
    output logic        duck_visible,
    output logic        duck_escaped,
    output logic        duck_landed
);

    localparam logic [11:0] X_MAX   = 12'(SCREEN_W - DUCK_W);
    localparam logic [11:0] Y_GND   = 12'(GROUND_Y - DUCK_H);
    localparam logic [11:0] SPD0    = 12'(START_SPEED);
    localparam logic [11:0] SPD_MAX = 12'(MAX_SPEED);
    localparam logic [11:0] FALL    = 12'(FALL_STEP);
    localparam logic [15:0] FLY_END = 16'(FLY_TICKS);
    localparam logic [15:0] HIT_END = 16'(HIT_TICKS);
    localparam int          TW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_FLYING   = 3'd1,
        S_ESCAPING = 3'd2,
        S_HIT      = 3'd3,
        S_FALLING  = 3'd4
    } state_t;

    state_t         state_q, state_d;
    logic [11:0]    x_q, x_d, y_q, y_d, speed_q, speed_d;
    logic           dir_q, dir_d, vup_q, vup_d;
    logic [15:0]    timer_q, timer_d, lfsr_q, lfsr_d;
    logic [TW-1:0]  tick_cnt_q, tick_cnt_d;
    logic           vis_q, vis_d, esc_q, esc_d, land_q, land_d;
    logic           tick;
    logic [11:0]    spawn_x;

    assign tick = (tick_cnt_q == TICK_LAST);

    // A raw 10-bit LFSR value can land past the right wall; folding it back
    // by 512 keeps the spawn on screen without a divider.
    assign spawn_x = ({2'b00, lfsr_q[9:0]} > X_MAX) ? ({2'b00, lfsr_q[9:0]} - 12'd512)
                                                     : {2'b00, lfsr_q[9:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            x_q        <= '0;
            y_q        <= Y_GND;
            dir_q      <= 1'b1;
            vup_q      <= 1'b1;
            speed_q    <= SPD0;
            timer_q    <= '0;
            lfsr_q     <= 16'hACE1;
            tick_cnt_q <= '0;
            vis_q      <= 1'b0;
            esc_q      <= 1'b0;
            land_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            dir_q      <= dir_d;
            vup_q      <= vup_d;
            speed_q    <= speed_d;
            timer_q    <= timer_d;
            lfsr_q     <= lfsr_d;
            tick_cnt_q <= tick_cnt_d;
            vis_q      <= vis_d;
            esc_q      <= esc_d;
            land_q     <= land_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        dir_d      = dir_q;
        vup_d      = vup_q;
        speed_d    = speed_q;
        timer_d    = timer_q;
        esc_d      = 1'b0;
        land_d     = 1'b0;
        tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
        // Fibonacci taps 16, 14, 13, 11
        lfsr_d     = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

        if (!game_enable) begin
            state_d = S_IDLE;
            x_d     = '0;
            y_d     = Y_GND;
            dir_d   = 1'b1;
            vup_d   = 1'b1;
            speed_d = SPD0;
            timer_d = '0;
        end else if ((state_q == S_FLYING || state_q == S_ESCAPING) && duck_killed) begin
            // A kill outranks any motion, bounce or timeout in the same cycle.
            state_d = S_HIT;
            timer_d = '0;
            speed_d = (speed_q >= SPD_MAX) ? SPD_MAX : speed_q + 12'd1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (hunt_start) begin
                        state_d = S_FLYING;
                        x_d     = spawn_x;
                        y_d     = Y_GND;
                        dir_d   = lfsr_q[15];
                        vup_d   = 1'b1;
                        timer_d = '0;
                    end
                end
                S_FLYING: begin
                    if (tick) begin
                        // Compare before stepping so 12-bit math never wraps.
                        if (dir_q) begin
                            if (x_q + speed_q >= X_MAX) begin
                                x_d   = X_MAX;
                                dir_d = 1'b0;
                            end else begin
                                x_d = x_q + speed_q;
                            end
                        end else begin
                            if (x_q <= speed_q) begin
                                x_d   = '0;
                                dir_d = 1'b1;
                            end else begin
                                x_d = x_q - speed_q;
                            end
                        end
                        if (vup_q) begin
                            if (y_q <= speed_q) begin
                                y_d   = '0;
                                vup_d = 1'b0;
                            end else begin
                                y_d = y_q - speed_q;
                            end
                        end else begin
                            if (y_q + speed_q >= Y_GND) begin
                                y_d   = Y_GND;
                                vup_d = 1'b1;
                            end else begin
                                y_d = y_q + speed_q;
                            end
                        end
                        timer_d = timer_q + 16'd1;
                        if (timer_q + 16'd1 == FLY_END) state_d = S_ESCAPING;
                    end
                end
                S_ESCAPING: begin
                    if (tick) begin
                        if (y_q <= speed_q) begin
                            y_d     = '0;
                            esc_d   = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            y_d = y_q - speed_q;
                        end
                    end
                end
                S_HIT: begin
                    if (tick) begin
                        timer_d = timer_q + 16'd1;
                        if (timer_q + 16'd1 == HIT_END) state_d = S_FALLING;
                    end
                end
                S_FALLING: begin
                    if (tick) begin
                        if (y_q + FALL >= Y_GND) begin
                            y_d     = Y_GND;
                            land_d  = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            y_d = y_q + FALL;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        vis_d = (state_d != S_IDLE);
    end

    assign duck_xpos    = x_q;
    assign duck_ypos    = y_q;
    assign duck_dir     = dir_q;
    assign duck_state   = state_q;
    assign duck_visible = vis_q;
    assign duck_escaped = esc_q;
    assign duck_landed  = land_q;

endmodule

// File: tb/tb_duck_motion_ctl.sv
// Testbench for duck_motion_ctl with shortened timing (TICK_DIV=4,
// FLY_TICKS=10, HIT_TICKS=3). A behavioural model tracks the duck with plain
// signed arithmetic and is compared against every output on every cycle.

module tb_duck_motion_ctl;

    localparam int TICK_DIV    = 4;
    localparam int FLY_TICKS   = 10;
    localparam int HIT_TICKS   = 3;
    localparam int X_MAX       = 928;
    localparam int Y_GND       = 540;
    localparam int START_SPEED = 2;
    localparam int MAX_SPEED   = 8;
    localparam int FALL_STEP   = 6;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic game_enable = 1'b0;
    logic hunt_start = 1'b0;
    logic duck_killed = 1'b0;
    logic [11:0] duck_xpos, duck_ypos;
    logic        duck_dir;
    logic [2:0]  duck_state;
    logic        duck_visible, duck_escaped, duck_landed;

    always #5 clk = ~clk;

    duck_motion_ctl #(
        .TICK_DIV (TICK_DIV),
        .FLY_TICKS(FLY_TICKS),
        .HIT_TICKS(HIT_TICKS)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .game_enable (game_enable),
        .hunt_start  (hunt_start),
        .duck_killed (duck_killed),
        .duck_xpos   (duck_xpos),
        .duck_ypos   (duck_ypos),
        .duck_dir    (duck_dir),
        .duck_state  (duck_state),
        .duck_visible(duck_visible),
        .duck_escaped(duck_escaped),
        .duck_landed (duck_landed)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog expired");
    end

    // ---------------- reference model ----------------
    int          m_state, m_x, m_y, m_dir, m_vup, m_speed, m_timer, m_cyc, m_esc, m_land;
    logic [15:0] m_lfsr;

    task automatic model_reset();
        m_state = 0; m_x = 0; m_y = Y_GND; m_dir = 1; m_vup = 1;
        m_speed = START_SPEED; m_timer = 0; m_cyc = 0; m_esc = 0; m_land = 0;
        m_lfsr = 16'hACE1;
    endtask

    task automatic model_step();
        bit tick;
        int nx, ny;
        tick = ((m_cyc % TICK_DIV) == TICK_DIV - 1);
        m_cyc++;
        m_esc = 0;
        m_land = 0;
        if (!game_enable) begin
            m_state = 0; m_x = 0; m_y = Y_GND; m_dir = 1; m_speed = START_SPEED;
        end else if (m_state == 0) begin
            if (hunt_start) begin
                m_x = int'(m_lfsr[9:0]);
                if (m_x > X_MAX) m_x -= 512;
                m_y = Y_GND; m_dir = int'(m_lfsr[15]); m_vup = 1; m_timer = 0; m_state = 1;
            end
        end else if ((m_state == 1 || m_state == 2) && duck_killed) begin
            m_state = 3;
            m_timer = 0;
            m_speed = (m_speed + 1 > MAX_SPEED) ? MAX_SPEED : m_speed + 1;
        end else if (tick) begin
            case (m_state)
                1: begin
                    nx = m_x + ((m_dir != 0) ? m_speed : -m_speed);
                    if (nx >= X_MAX) begin nx = X_MAX; m_dir = 0; end
                    else if (nx <= 0) begin nx = 0; m_dir = 1; end
                    ny = m_y + ((m_vup != 0) ? -m_speed : m_speed);
                    if (ny <= 0) begin ny = 0; m_vup = 0; end
                    else if (ny >= Y_GND) begin ny = Y_GND; m_vup = 1; end
                    m_x = nx;
                    m_y = ny;
                    m_timer++;
                    if (m_timer == FLY_TICKS) m_state = 2;
                end
                2: begin
                    if (m_y - m_speed <= 0) begin m_y = 0; m_esc = 1; m_state = 0; end
                    else m_y -= m_speed;
                end
                3: begin
                    m_timer++;
                    if (m_timer == HIT_TICKS) m_state = 4;
                end
                4: begin
                    if (m_y + FALL_STEP >= Y_GND) begin m_y = Y_GND; m_land = 1; m_state = 0; end
                    else m_y += FALL_STEP;
                end
                default: m_state = 0;
            endcase
        end
        m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else        model_step();
    end

    // ---------------- scoreboard ----------------
    int n_tests = 0;
    int n_fail  = 0;
    int esc_cnt = 0;
    int land_cnt = 0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One clock, then compare every output against the model at the negedge.
    task automatic cycle();
        logic [30:0] act, exp;
        @(posedge clk);
        @(negedge clk);
        esc_cnt  += int'(duck_escaped);
        land_cnt += int'(duck_landed);
        act = {duck_state, duck_xpos, duck_ypos, duck_dir, duck_visible, duck_escaped, duck_landed};
        exp = {3'(m_state), 12'(m_x), 12'(m_y), m_dir[0], (m_state != 0), m_esc[0], m_land[0]};
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL model t=%0t: got st=%0d x=%0d y=%0d dir=%0b vis=%0b esc=%0b land=%0b, expected st=%0d x=%0d y=%0d dir=%0d vis=%0b esc=%0d land=%0d",
                     $time, duck_state, duck_xpos, duck_ypos, duck_dir, duck_visible, duck_escaped,
                     duck_landed, m_state, m_x, m_y, m_dir, (m_state != 0), m_esc, m_land);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic ge;
        logic hs;
        logic kill;
        int   cycles;
        int   exp_state;
        int   exp_vis;
        int   exp_y;      // -1: not checked
    } vec_t;

    vec_t vecs[12];

    initial begin
        int x0, d0, exp_x, cand, found, bounced, e0, l0;

        // Timeline from reset release: motion ticks on edges 4, 8, 12, ...
        vecs[0]  = '{1'b1, 1'b0, 1'b0,   3, 0, 0, 540}; // idle, stable
        vecs[1]  = '{1'b1, 1'b1, 1'b0,   1, 1, 1, 540}; // spawn on edge 4
        vecs[2]  = '{1'b1, 1'b0, 1'b0,   4, 1, 1, 538}; // first tick (edge 8)
        vecs[3]  = '{1'b1, 1'b0, 1'b0,  28, 1, 1, 524}; // 8 ticks flown
        vecs[4]  = '{1'b1, 1'b0, 1'b1,   1, 3, 1, 524}; // kill on edge 37
        vecs[5]  = '{1'b1, 1'b0, 1'b0,  11, 4, 1, 524}; // 3 hit ticks -> FALLING at edge 48
        vecs[6]  = '{1'b1, 1'b0, 1'b0,  11, 4, 1, 536}; // 524 -> 530 -> 536
        vecs[7]  = '{1'b1, 1'b0, 1'b0,   1, 0, 0, 540}; // lands on edge 60
        vecs[8]  = '{1'b1, 1'b1, 1'b0,   1, 1, 1, 540}; // respawn, speed now 3
        vecs[9]  = '{1'b1, 1'b0, 1'b0,  39, 2, 1, 510}; // 10 ticks -> ESCAPING at edge 100
        vecs[10] = '{1'b1, 1'b0, 1'b0, 679, 2, 1,   3}; // 169 escape ticks
        vecs[11] = '{1'b1, 1'b0, 1'b0,   1, 0, 0,   0}; // escapes on edge 780

        // Reset state
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_state", int'(duck_state), 0);
        check("rst_ypos",  int'(duck_ypos), Y_GND);
        check("rst_xpos",  int'(duck_xpos), 0);
        check("rst_vis",   int'(duck_visible), 0);
        check("rst_dir",   int'(duck_dir), 1);
        check("rst_pulses", int'(duck_escaped) + int'(duck_landed), 0);
        rst_n = 1'b1;
        x0 = 0;
        d0 = 0;

        for (int i = 0; i < 12; i++) begin
            game_enable = vecs[i].ge;
            hunt_start  = vecs[i].hs;
            duck_killed = vecs[i].kill;
            repeat (vecs[i].cycles) cycle();
            check($sformatf("vec%0d_state", i), int'(duck_state), vecs[i].exp_state);
            check($sformatf("vec%0d_vis", i), int'(duck_visible), vecs[i].exp_vis);
            if (vecs[i].exp_y >= 0)
                check($sformatf("vec%0d_ypos", i), int'(duck_ypos), vecs[i].exp_y);
            if (i == 1) begin
                x0 = int'(duck_xpos);
                d0 = int'(duck_dir);
                check("spawn_x_in_range", int'(duck_xpos <= 12'd928), 1);
            end
            if (i == 2) begin
                if (d0 != 0) exp_x = (x0 + 2 >= X_MAX) ? X_MAX : x0 + 2;
                else         exp_x = (x0 <= 2) ? 0 : x0 - 2;
                check("first_step_x", int'(duck_xpos), exp_x);
            end
            if (i == 7)  check("landed_once", land_cnt, 1);
            if (i == 11) check("escaped_once", esc_cnt, 1);
        end
        duck_killed = 1'b0;
        hunt_start  = 1'b0;

        // Right-wall bounce: wait for an LFSR value that spawns within 7 px of
        // the wall facing right, then spawn there. Speed is 3 after one kill.
        found = 0;
        cand = 0;
        for (int k = 0; k < 5000 && found == 0; k++) begin
            cand = int'(m_lfsr[9:0]);
            if (cand > X_MAX) cand -= 512;
            if (cand >= X_MAX - 7 && m_lfsr[15]) found = 1;
            else cycle();
        end
        check("wall_seed_found", found, 1);
        if (found != 0) begin
            hunt_start = 1'b1;
            cycle();
            hunt_start = 1'b0;
            check("wall_spawn_x", int'(duck_xpos), cand);
            check("wall_spawn_dir", int'(duck_dir), 1);
            bounced = 0;
            for (int k = 0; k < 40 && bounced == 0; k++) begin
                cycle();
                if (duck_xpos == 12'd928 && duck_dir == 1'b0) bounced = 1;
            end
            check("wall_bounce", bounced, 1);
            for (int k = 0; k < 8 && duck_xpos == 12'd928; k++) cycle();
            check("wall_after_bounce_x", int'(duck_xpos), X_MAX - 3);
            check("wall_still_flying", int'(duck_state), 1);

            // Drop game_enable mid-flight
            e0 = esc_cnt;
            l0 = land_cnt;
            game_enable = 1'b0;
            cycle();
            game_enable = 1'b1;
            check("ge_off_state", int'(duck_state), 0);
            check("ge_off_xpos", int'(duck_xpos), 0);
            check("ge_off_ypos", int'(duck_ypos), Y_GND);
            check("ge_off_dir", int'(duck_dir), 1);
            check("ge_off_no_pulse", (esc_cnt - e0) + (land_cnt - l0), 0);
        end

        // Async reset during FALLING
        game_enable = 1'b1;
        hunt_start  = 1'b1;
        cycle();
        hunt_start  = 1'b0;
        duck_killed = 1'b1;
        cycle();
        duck_killed = 1'b0;
        check("kill_to_hit", int'(duck_state), 3);
        found = 0;
        for (int k = 0; k < 40 && found == 0; k++) begin
            cycle();
            if (duck_state == 3'd4) found = 1;
        end
        check("reach_falling", found, 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_state", int'(duck_state), 0);
        check("arst_xpos", int'(duck_xpos), 0);
        check("arst_ypos", int'(duck_ypos), Y_GND);
        check("arst_dir", int'(duck_dir), 1);
        check("arst_vis", int'(duck_visible), 0);
        @(negedge clk);
        rst_n = 1'b1;
        hunt_start = 1'b1;
        cycle();
        hunt_start = 1'b0;
        check("post_rst_spawn", int'(duck_state), 1);
        cycle();
        cycle();
        check("post_rst_no_tick_yet", int'(duck_ypos), Y_GND);
        cycle();
        check("post_rst_first_tick", int'(duck_ypos), Y_GND - START_SPEED);

        // Randomized traffic against the model
        for (int k = 0; k < 3000; k++) begin
            game_enable = ($urandom_range(0, 99) < 98);
            hunt_start  = ($urandom_range(0, 99) < 70);
            duck_killed = ($urandom_range(0, 99) < 2);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
